// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of issue, writeback and register-file write signals between the
// pipeline and regfile_wb_scheduler.
interface regfile_wb_scheduler_if;
    logic        issue_valid;
    logic        issue_we;
    logic        issue_long;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_use1;
    logic        issue_use2;
    logic        stall;

    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;

    logic        long_wb_valid;
    logic [4:0]  long_wb_rd;
    logic [31:0] long_wb_data;
    logic        long_wb_ready;

    logic        Wreg;
    logic [4:0]  rd;
    logic [31:0] Wdata;

    // Pipeline side: drives issue and writeback requests.
    modport master (
        output issue_valid, issue_we, issue_long, issue_rd, issue_rs1, issue_rs2,
               issue_use1, issue_use2,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output long_wb_valid, long_wb_rd, long_wb_data,
        input  stall, long_wb_ready, Wreg, rd, Wdata
    );

    // Scheduler side.
    modport slave (
        input  issue_valid, issue_we, issue_long, issue_rd, issue_rs1, issue_rs2,
               issue_use1, issue_use2,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  long_wb_valid, long_wb_rd, long_wb_data,
        output stall, long_wb_ready, Wreg, rd, Wdata
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port arbiter (ALU over long-op) and busy-register
// scoreboard producing the decode issue stall.
module regfile_wb_scheduler #(
    parameter int unsigned MAX_LONG     = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                   Clock,
    input  logic                   nReset,
    regfile_wb_scheduler_if.slave  bus
);
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned LCW   = 4;
    localparam int unsigned SCW   = 8;

    logic [NREGS-1:0] busy_q, busy_d, busy_set, busy_clr;
    logic [LCW-1:0]   long_cnt_q, long_cnt_d;
    logic [SCW-1:0]   starve_cnt_q, starve_cnt_d;
    logic             wreg_q, wreg_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [DW-1:0]    wdata_q, wdata_d;

    logic stall_c;
    logic accept;
    logic hazard;
    logic long_full;
    logic starved;
    logic long_take;
    logic long_inc;
    logic long_dec;

    // Issue stall: operand/destination hazards, long-op capacity, starvation.
    always_comb begin
        long_full = (long_cnt_q == LCW'(MAX_LONG));
        starved   = (starve_cnt_q == SCW'(STARVE_LIMIT));
        hazard    = (bus.issue_use1 && busy_q[bus.issue_rs1]) ||
                    (bus.issue_use2 && busy_q[bus.issue_rs2]) ||
                    (bus.issue_we   && busy_q[bus.issue_rd]);
        stall_c   = bus.issue_valid &&
                    (hazard || (bus.issue_long && long_full) || starved);
        accept    = bus.issue_valid && !stall_c;
    end

    // ALU results cannot wait, so the long unit only gets free cycles.
    assign long_take = bus.long_wb_valid && !bus.alu_wb_valid;

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (accept && bus.issue_we && (bus.issue_rd != '0)) begin
            busy_set[bus.issue_rd] = 1'b1;
        end
        // The register file commits while Wreg is high; clear on that edge.
        if (wreg_q) begin
            busy_clr[rd_q] = 1'b1;
        end
        busy_d    = (busy_q & ~busy_clr) | busy_set;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        long_inc   = accept && bus.issue_long;
        long_dec   = long_take && (long_cnt_q != '0);
        long_cnt_d = long_cnt_q;
        unique case ({long_inc, long_dec})
            2'b10:   long_cnt_d = long_cnt_q + LCW'(1);
            2'b01:   long_cnt_d = long_cnt_q - LCW'(1);
            default: long_cnt_d = long_cnt_q;
        endcase
    end

    // Counts consecutive cycles a pending long result loses to the ALU.
    always_comb begin
        starve_cnt_d = '0;
        if (bus.long_wb_valid && bus.alu_wb_valid) begin
            if (starved) begin
                starve_cnt_d = starve_cnt_q;
            end else begin
                starve_cnt_d = starve_cnt_q + SCW'(1);
            end
        end
    end

    always_comb begin
        wreg_d  = 1'b0;
        rd_d    = rd_q;
        wdata_d = wdata_q;
        if (bus.alu_wb_valid) begin
            wreg_d  = (bus.alu_wb_rd != '0);
            rd_d    = bus.alu_wb_rd;
            wdata_d = bus.alu_wb_data;
        end else if (bus.long_wb_valid) begin
            wreg_d  = (bus.long_wb_rd != '0);
            rd_d    = bus.long_wb_rd;
            wdata_d = bus.long_wb_data;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            busy_q       <= '0;
            long_cnt_q   <= '0;
            starve_cnt_q <= '0;
            wreg_q       <= 1'b0;
            rd_q         <= '0;
            wdata_q      <= '0;
        end else begin
            busy_q       <= busy_d;
            long_cnt_q   <= long_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            wreg_q       <= wreg_d;
            rd_q         <= rd_d;
            wdata_q      <= wdata_d;
        end
    end

    assign bus.stall         = stall_c;
    assign bus.long_wb_ready = long_take;
    assign bus.Wreg          = wreg_q;
    assign bus.rd            = rd_q;
    assign bus.Wdata         = wdata_q;

    // Protocol checks on the long-op unit.
    a_long_no_underflow: assert property (
        @(posedge Clock) disable iff (!nReset) long_take |-> (long_cnt_q != '0))
        else $error("long writeback accepted with no outstanding long op");

    a_long_bounded: assert property (
        @(posedge Clock) disable iff (!nReset) long_cnt_q <= LCW'(MAX_LONG))
        else $error("long op count above MAX_LONG");
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with a behavioural scoreboard model.
module tb_regfile_wb_scheduler;
    localparam int unsigned MAX_LONG     = 4;
    localparam int unsigned STARVE_LIMIT = 8;

    logic Clock;
    logic nReset;
    int   checks = 0;
    int   errors = 0;

    regfile_wb_scheduler_if bus ();

    regfile_wb_scheduler #(
        .MAX_LONG     (MAX_LONG),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Model: set of registers awaiting writeback, outstanding long ops,
    // consecutive denied long cycles, and the write last scheduled.
    bit          mbusy [32];
    int          mlong;
    int          mstarve;
    logic        exp_wreg;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_stall();
        bit waits;
        waits = (bus.issue_use1 && mbusy[bus.issue_rs1]) ||
                (bus.issue_use2 && mbusy[bus.issue_rs2]) ||
                (bus.issue_we   && mbusy[bus.issue_rd])  ||
                (bus.issue_long && mlong >= int'(MAX_LONG)) ||
                (mstarve >= int'(STARVE_LIMIT));
        return bus.issue_valid && waits;
    endfunction

    initial begin
        forever begin
            @(posedge Clock or negedge nReset);
            if (!nReset) begin
                foreach (mbusy[i]) mbusy[i] = 1'b0;
                mlong     = 0;
                mstarve   = 0;
                exp_wreg  = 1'b0;
                exp_rd    = '0;
                exp_wdata = '0;
            end else begin
                bit acc;
                acc = bus.issue_valid && !m_stall();
                if (exp_wreg) mbusy[exp_rd] = 1'b0;
                if (acc && bus.issue_we && bus.issue_rd != 5'd0) mbusy[bus.issue_rd] = 1'b1;
                if (acc && bus.issue_long) mlong++;
                if (bus.long_wb_valid && !bus.alu_wb_valid) mlong--;
                if (bus.long_wb_valid && bus.alu_wb_valid)
                    mstarve = (mstarve < int'(STARVE_LIMIT)) ? mstarve + 1 : int'(STARVE_LIMIT);
                else
                    mstarve = 0;
                if (bus.alu_wb_valid) begin
                    exp_wreg  = (bus.alu_wb_rd != 5'd0);
                    exp_rd    = bus.alu_wb_rd;
                    exp_wdata = bus.alu_wb_data;
                end else if (bus.long_wb_valid) begin
                    exp_wreg  = (bus.long_wb_rd != 5'd0);
                    exp_rd    = bus.long_wb_rd;
                    exp_wdata = bus.long_wb_data;
                end else begin
                    exp_wreg = 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    initial begin
        forever begin
            @(negedge Clock);
            chk("m_stall", 32'(bus.stall), 32'(m_stall()));
            chk("m_ready", 32'(bus.long_wb_ready), 32'(bus.long_wb_valid && !bus.alu_wb_valid));
            chk("m_wreg",  32'(bus.Wreg), 32'(exp_wreg));
            chk("m_rd",    32'(bus.rd), 32'(exp_rd));
            chk("m_wdata", bus.Wdata, exp_wdata);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic idle();
        bus.issue_valid   = 1'b0;
        bus.issue_we      = 1'b0;
        bus.issue_long    = 1'b0;
        bus.issue_rd      = '0;
        bus.issue_rs1     = '0;
        bus.issue_rs2     = '0;
        bus.issue_use1    = 1'b0;
        bus.issue_use2    = 1'b0;
        bus.alu_wb_valid  = 1'b0;
        bus.alu_wb_rd     = '0;
        bus.alu_wb_data   = '0;
        bus.long_wb_valid = 1'b0;
        bus.long_wb_rd    = '0;
        bus.long_wb_data  = '0;
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic issue(input logic we, input logic lng, input logic [4:0] r,
                         input logic [4:0] s1, input logic [4:0] s2,
                         input logic u1, input logic u2);
        bus.issue_valid = 1'b1;
        bus.issue_we    = we;
        bus.issue_long  = lng;
        bus.issue_rd    = r;
        bus.issue_rs1   = s1;
        bus.issue_rs2   = s2;
        bus.issue_use1  = u1;
        bus.issue_use2  = u2;
    endtask

    task automatic alu(input logic [4:0] r, input logic [31:0] d);
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd    = r;
        bus.alu_wb_data  = d;
    endtask

    task automatic lwb(input logic [4:0] r, input logic [31:0] d);
        bus.long_wb_valid = 1'b1;
        bus.long_wb_rd    = r;
        bus.long_wb_data  = d;
    endtask

    initial begin
        idle();
        nReset = 1'b0;
        repeat (2) @(posedge Clock);
        #2;
        chk("rst_wreg",  32'(bus.Wreg), 32'd0);
        chk("rst_rd",    32'(bus.rd), 32'd0);
        chk("rst_wdata", bus.Wdata, 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        #1 nReset = 1'b1;

        // RAW through an ALU writeback
        cyc(); issue(1, 0, 5'd7, 0, 0, 0, 0);
        #1 chk("raw_issue", 32'(bus.stall), 32'd0);
        cyc(); issue(0, 0, 0, 5'd7, 0, 1, 0); alu(5'd7, 32'h0000_00AB);
        #1 chk("raw_stall0", 32'(bus.stall), 32'd1);
        cyc(); issue(0, 0, 0, 5'd7, 0, 1, 0);
        #1 chk("raw_stall1", 32'(bus.stall), 32'd1);
        chk("raw_wreg",  32'(bus.Wreg), 32'd1);
        chk("raw_rd",    32'(bus.rd), 32'd7);
        chk("raw_wdata", bus.Wdata, 32'h0000_00AB);
        cyc(); issue(0, 0, 0, 5'd7, 0, 1, 0);
        #1 chk("raw_release", 32'(bus.stall), 32'd0);
        chk("raw_wreg_off", 32'(bus.Wreg), 32'd0);

        // ALU / long collision
        cyc(); issue(1, 1, 5'd4, 0, 0, 0, 0);
        #1 chk("col_issue", 32'(bus.stall), 32'd0);
        cyc(); alu(5'd3, 32'h11); lwb(5'd4, 32'h22);
        #1 chk("col_ready0", 32'(bus.long_wb_ready), 32'd0);
        cyc(); lwb(5'd4, 32'h22);
        #1 chk("col_ready1", 32'(bus.long_wb_ready), 32'd1);
        chk("col_rd_alu",    32'(bus.rd), 32'd3);
        chk("col_wdata_alu", bus.Wdata, 32'h11);
        cyc();
        #1 chk("col_wreg_long", 32'(bus.Wreg), 32'd1);
        chk("col_rd_long",    32'(bus.rd), 32'd4);
        chk("col_wdata_long", bus.Wdata, 32'h22);
        cyc();
        #1 chk("col_hold_rd", 32'(bus.rd), 32'd4);

        // Long-op capacity
        for (int i = 0; i < 4; i++) begin
            cyc(); issue(1, 1, 5'(10 + i), 0, 0, 0, 0);
            #1 chk("cap_issue", 32'(bus.stall), 32'd0);
        end
        cyc(); issue(1, 1, 5'd14, 0, 0, 0, 0);
        #1 chk("cap_full", 32'(bus.stall), 32'd1);
        cyc(); issue(1, 1, 5'd14, 0, 0, 0, 0); lwb(5'd10, 32'h100);
        #1 chk("cap_full_wb", 32'(bus.stall), 32'd1);
        cyc(); issue(1, 1, 5'd14, 0, 0, 0, 0);
        #1 chk("cap_freed", 32'(bus.stall), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(); lwb(5'(11 + i), 32'(32'h200 + i));
            #1 chk("cap_drain", 32'(bus.long_wb_ready), 32'd1);
        end
        cyc();

        // Writeback starvation
        cyc(); issue(1, 1, 5'd20, 0, 0, 0, 0);
        #1 chk("stv_issue", 32'(bus.stall), 32'd0);
        for (int c = 1; c <= 10; c++) begin
            cyc(); issue(0, 0, 0, 0, 0, 0, 0); alu(5'd21, 32'(c)); lwb(5'd20, 32'h55);
            #1 chk("stv_count", 32'(bus.stall), 32'(c >= 9));
        end
        cyc(); issue(0, 0, 0, 0, 0, 0, 0); lwb(5'd20, 32'h55);
        #1 chk("stv_grant_stall", 32'(bus.stall), 32'd1);
        chk("stv_grant_ready", 32'(bus.long_wb_ready), 32'd1);
        cyc(); issue(0, 0, 0, 0, 0, 0, 0);
        #1 chk("stv_release", 32'(bus.stall), 32'd0);
        chk("stv_wdata", bus.Wdata, 32'h55);

        // x0 handling
        cyc(); alu(5'd0, 32'hFFFF_FFFF); issue(1, 0, 5'd0, 0, 0, 0, 0);
        #1 chk("x0_issue_rd0", 32'(bus.stall), 32'd0);
        cyc(); issue(0, 0, 0, 5'd0, 5'd0, 1, 1);
        #1 chk("x0_src", 32'(bus.stall), 32'd0);
        chk("x0_wreg",  32'(bus.Wreg), 32'd0);
        chk("x0_rd",    32'(bus.rd), 32'd0);
        chk("x0_wdata", bus.Wdata, 32'hFFFF_FFFF);
        cyc(); issue(1, 0, 5'd0, 5'd0, 0, 1, 0);
        #1 chk("x0_waw", 32'(bus.stall), 32'd0);

        // Reset in the middle of activity
        cyc(); issue(1, 0, 5'd5, 0, 0, 0, 0); alu(5'd6, 32'h77);
        cyc(); issue(1, 1, 5'd8, 0, 0, 0, 0);
        cyc(); issue(1, 1, 5'd9, 0, 0, 0, 0);
        cyc();
        #1 nReset = 1'b0;
        #1 chk("mrst_wreg", 32'(bus.Wreg), 32'd0);
        chk("mrst_rd",    32'(bus.rd), 32'd0);
        chk("mrst_wdata", bus.Wdata, 32'd0);
        @(posedge Clock);
        #3 nReset = 1'b1;
        cyc(); issue(0, 0, 0, 5'd5, 0, 1, 0);
        #1 chk("mrst_rs1_busy5", 32'(bus.stall), 32'd0);
        cyc(); issue(1, 1, 5'd8, 0, 0, 0, 0);
        #1 chk("mrst_waw_rd8", 32'(bus.stall), 32'd0);
        cyc(); lwb(5'd8, 32'h1);
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
